// File: rtl/hwag_out_pkg.sv
// Shared types and helpers for the HWAG angle-domain output stage.
// Build option: HWAG_OUT_DWELL_LIMIT_EN enables the per-channel dwell limiter.
package hwag_out_pkg;

    localparam int HWAG_AW = 24;

    typedef enum logic [1:0] {
        OCH_IDLE   = 2'd0,
        OCH_ARMED  = 2'd1,
        OCH_ACTIVE = 2'd2
    } och_state_t;

    function automatic int OCH_ADDR_DWELL(input int ch);
        return 2 * ch;
    endfunction

    // Target t was crossed moving from prev to cur; a backwards move is a wrap through angle_max.
    function automatic logic angle_hit(
        input logic [HWAG_AW-1:0] prev,
        input logic [HWAG_AW-1:0] cur,
        input logic [HWAG_AW-1:0] t,
        input logic [HWAG_AW-1:0] amax
    );
        logic hit;
        if (t > amax) begin
            hit = 1'b0;
        end else if (cur > prev) begin
            hit = (t > prev) && (t <= cur);
        end else if (cur < prev) begin
            hit = (t > prev) || (t <= cur);
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

endpackage

// File: rtl/hwag_out_channel.sv
// One angle-window output channel: FSM, double-buffered on/off angles, deferred update.
// Build option: HWAG_OUT_DWELL_LIMIT_EN adds the dwell counter and sticky fault.
module hwag_out_channel
    import hwag_out_pkg::*;
#(
    parameter int AW = HWAG_AW
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    ,
    parameter int DW = 24
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          ch_ena,
    input  logic          upd,
    input  logic [AW-1:0] prev_angle,
    input  logic [AW-1:0] angle,
    input  logic [AW-1:0] angle_max,
    input  logic          on_we,
    input  logic          off_we,
    input  logic [AW-1:0] wdata,
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    input  logic [DW-1:0] dwell_max,
    input  logic          fault_clr,
`endif
    output logic          out,
    output logic          on_if,
    output logic          fault
);

    och_state_t    state_r, state_nx;
    logic [AW-1:0] sh_on_r, sh_off_r, act_on_r, act_off_r;
    logic          pend_r, pend_nx;
    logic          xfer_s, hit_on_s, hit_off_s, trip_s;
    logic          out_r, on_if_r, out_s, on_if_s;

    assign hit_on_s  = angle_hit(prev_angle, angle, act_on_r, angle_max);
    assign hit_off_s = angle_hit(prev_angle, angle, act_off_r, angle_max);

`ifdef HWAG_OUT_DWELL_LIMIT_EN
    logic [DW-1:0] dwell_cnt_r, dwell_inc_s;
    logic          fault_r;

    assign dwell_inc_s = dwell_cnt_r + DW'(1);
    // Trip only when the limit is the actual reason for leaving ACTIVE.
    assign trip_s = ena && ch_ena && (state_r == OCH_ACTIVE) && !hit_off_s &&
                    (dwell_max != {DW{1'b0}}) && (dwell_inc_s == dwell_max);

    // Dwell counter restarts on every ACTIVE entry; sticky fault, set wins over clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dwell_cnt_r <= {DW{1'b0}};
            fault_r     <= 1'b0;
        end else begin
            if (state_r == OCH_ACTIVE) begin
                dwell_cnt_r <= dwell_inc_s;
            end else begin
                dwell_cnt_r <= {DW{1'b0}};
            end
            if (trip_s) begin
                fault_r <= 1'b1;
            end else if (fault_clr) begin
                fault_r <= 1'b0;
            end else begin
                fault_r <= fault_r;
            end
        end
    end

    assign fault = fault_r;
`else
    assign trip_s = 1'b0;
    assign fault  = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        if (!ena || !ch_ena) begin
            state_nx = OCH_IDLE;
        end else begin
            case (state_r)
                OCH_IDLE: state_nx = OCH_ARMED;
                OCH_ARMED: begin
                    if (hit_on_s && !hit_off_s) begin
                        state_nx = OCH_ACTIVE;
                    end else begin
                        state_nx = OCH_ARMED;
                    end
                end
                OCH_ACTIVE: begin
                    if (hit_off_s || trip_s) begin
                        state_nx = OCH_ARMED;
                    end else begin
                        state_nx = OCH_ACTIVE;
                    end
                end
                default: state_nx = OCH_IDLE;
            endcase
        end
    end

    // Output and shadow-transfer decode; an update seen while ACTIVE is held until the pulse ends.
    always_comb begin
        out_s   = (state_nx == OCH_ACTIVE);
        on_if_s = (state_r == OCH_ARMED) && (state_nx == OCH_ACTIVE);
        xfer_s  = 1'b0;
        pend_nx = pend_r;
        if (state_r != OCH_ACTIVE) begin
            xfer_s  = upd;
            pend_nx = 1'b0;
        end else if (upd || pend_r) begin
            if (state_nx != OCH_ACTIVE) begin
                xfer_s  = 1'b1;
                pend_nx = 1'b0;
            end else begin
                pend_nx = 1'b1;
            end
        end else begin
            pend_nx = 1'b0;
        end
    end

    // State, pending flag and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= OCH_IDLE;
            pend_r  <= 1'b0;
            out_r   <= 1'b0;
            on_if_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            pend_r  <= pend_nx;
            out_r   <= out_s;
            on_if_r <= on_if_s;
        end
    end

    // Angle registers; the transfer samples shadow values before a same-clock write lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_on_r   <= {AW{1'b0}};
            sh_off_r  <= {AW{1'b0}};
            act_on_r  <= {AW{1'b0}};
            act_off_r <= {AW{1'b0}};
        end else begin
            if (xfer_s) begin
                act_on_r  <= sh_on_r;
                act_off_r <= sh_off_r;
            end
            if (on_we) begin
                sh_on_r <= wdata;
            end
            if (off_we) begin
                sh_off_r <= wdata;
            end
        end
    end

    assign out   = out_r;
    assign on_if = on_if_r;

endmodule

// File: rtl/hwag_out_ctrl.sv
// HWAG angle-domain output controller: config decode, angle history, CH output channels.
// Build option: HWAG_OUT_DWELL_LIMIT_EN enables the dwell-limit register and channel faults.
module hwag_out_ctrl
    import hwag_out_pkg::*;
#(
    parameter int CH = 4,
    parameter int AW = HWAG_AW,
    parameter int DW = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic [AW-1:0]                angle,
    input  logic [AW-1:0]                angle_max,
    input  logic                         upd,
    input  logic                         cfg_we,
    input  logic [$clog2(2*CH+1)-1:0]    cfg_addr,
    input  logic [AW-1:0]                cfg_data,
    input  logic [CH-1:0]                ch_ena,
    input  logic [CH-1:0]                fault_clr,
    output logic [CH-1:0]                out,
    output logic [CH-1:0]                on_if,
    output logic [CH-1:0]                fault
);

    localparam int ADW = $clog2(2*CH+1);

    logic [AW-1:0] prev_angle_r;

    // Angle sampled last clock, the start point of this clock's crossing test.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_angle_r <= {AW{1'b0}};
        end else begin
            prev_angle_r <= angle;
        end
    end

`ifdef HWAG_OUT_DWELL_LIMIT_EN
    logic [DW-1:0] dwell_max_r;

    // Dwell limit shared by all channels; zero disables it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dwell_max_r <= {DW{1'b0}};
        end else if (cfg_we && (cfg_addr == ADW'(OCH_ADDR_DWELL(CH)))) begin
            dwell_max_r <= cfg_data[DW-1:0];
        end else begin
            dwell_max_r <= dwell_max_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{fault_clr, {DW{1'b0}}};
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic on_we_s, off_we_s;

        assign on_we_s  = cfg_we && (cfg_addr == ADW'(2*i));
        assign off_we_s = cfg_we && (cfg_addr == ADW'(2*i+1));

        hwag_out_channel #(
            .AW(AW)
`ifdef HWAG_OUT_DWELL_LIMIT_EN
            ,
            .DW(DW)
`endif
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .ena       (ena),
            .ch_ena    (ch_ena[i]),
            .upd       (upd),
            .prev_angle(prev_angle_r),
            .angle     (angle),
            .angle_max (angle_max),
            .on_we     (on_we_s),
            .off_we    (off_we_s),
            .wdata     (cfg_data),
`ifdef HWAG_OUT_DWELL_LIMIT_EN
            .dwell_max (dwell_max_r),
            .fault_clr (fault_clr[i]),
`endif
            .out       (out[i]),
            .on_if     (on_if[i]),
            .fault     (fault[i])
        );
    end

endmodule

// File: tb/tb_hwag_out_ctrl.sv
// Scoreboard bench for hwag_out_ctrl: directed angle scenarios plus randomized traffic
// against an arithmetic reference model. Honors HWAG_OUT_DWELL_LIMIT_EN.
module tb_hwag_out_ctrl;

    localparam int CH   = 4;
    localparam int AW   = 24;
    localparam int DW   = 24;
    localparam int ADW  = $clog2(2*CH+1);
    localparam int AMAX = 359;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_ARMED = 1, S_ACTIVE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, ena, upd, cfg_we;
    logic [AW-1:0]  angle, angle_max, cfg_data;
    logic [ADW-1:0] cfg_addr;
    logic [CH-1:0]  ch_ena, fault_clr, out, on_if, fault;

    hwag_out_ctrl #(.CH(CH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .angle(angle), .angle_max(angle_max),
        .upd(upd), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .ch_ena(ch_ena), .fault_clr(fault_clr), .out(out), .on_if(on_if), .fault(fault)
    );

    typedef struct {
        logic [3*CH-1:0] e;
        bit              cnt;
        bit              last;
        int              ehi;
        int              ep;
        int              seg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    int   hi_cnt = 0, pulse_cnt = 0;
    bit   g_cnt = 1'b0;
    int   g_seg = 0;

    // Reference model state
    int m_state[CH], m_sh_on[CH], m_sh_off[CH], m_on[CH], m_off[CH], m_entry[CH];
    bit m_pend[CH], m_fault[CH];
    int m_dmax = 0, m_prev = 0, cyc = 0;

    // Target crossed: its forward distance from prev lies inside the distance travelled.
    function automatic bit m_hit(input int prev, input int cur, input int t, input int mx);
        int m, span, d;
        if (t > mx || cur == prev) return 1'b0;
        m    = mx + 1;
        span = (cur - prev + m) % m;
        d    = (t - prev + m) % m;
        return (d >= 1) && (d <= span);
    endfunction

    task automatic model_step(output logic [3*CH-1:0] e);
        e = {3*CH{1'b0}};
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                m_state[c] = S_IDLE; m_sh_on[c] = 0; m_sh_off[c] = 0; m_on[c] = 0; m_off[c] = 0;
                m_pend[c] = 1'b0; m_fault[c] = 1'b0; m_entry[c] = 0;
            end
            m_dmax = 0;
            m_prev = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                int old, nw;
                bit hon, hoff, trip;
                hon  = m_hit(m_prev, int'(angle), m_on[c], int'(angle_max));
                hoff = m_hit(m_prev, int'(angle), m_off[c], int'(angle_max));
                trip = 1'b0;
                old  = m_state[c];
                if (!(ena && ch_ena[c])) nw = S_IDLE;
                else if (old == S_IDLE) nw = S_ARMED;
                else if (old == S_ARMED) nw = (hon && !hoff) ? S_ACTIVE : S_ARMED;
                else if (hoff) nw = S_ARMED;
                else if (DWELL_EN && m_dmax != 0 && (cyc - m_entry[c]) == m_dmax) begin
                    nw = S_ARMED; trip = 1'b1;
                end else nw = S_ACTIVE;
                if (nw == S_ACTIVE && old != S_ACTIVE) m_entry[c] = cyc;
                if (trip) m_fault[c] = 1'b1;
                else if (fault_clr[c]) m_fault[c] = 1'b0;
                if (old != S_ACTIVE) begin
                    if (upd) begin m_on[c] = m_sh_on[c]; m_off[c] = m_sh_off[c]; end
                end else if (upd || m_pend[c]) begin
                    if (nw != S_ACTIVE) begin
                        m_on[c] = m_sh_on[c]; m_off[c] = m_sh_off[c]; m_pend[c] = 1'b0;
                    end else m_pend[c] = 1'b1;
                end
                m_state[c]    = nw;
                e[c]          = (nw == S_ACTIVE);
                e[CH + c]     = (old == S_ARMED) && (nw == S_ACTIVE);
                e[2 * CH + c] = m_fault[c] && DWELL_EN;
            end
            if (cfg_we) begin
                int a;
                a = int'(cfg_addr);
                if (a < 2 * CH) begin
                    if (a % 2 == 0) m_sh_on[a / 2] = int'(cfg_data);
                    else m_sh_off[a / 2] = int'(cfg_data);
                end else if (a == 2 * CH && DWELL_EN) m_dmax = int'(cfg_data);
            end
            m_prev = int'(angle);
        end
        cyc++;
    endtask

    task automatic cycle(input bit last = 1'b0, input int ehi = 0, input int ep = 0);
        exp_t x;
        model_step(x.e);
        x.cnt = g_cnt && !last; x.last = last; x.ehi = ehi; x.ep = ep; x.seg = g_seg;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic wr(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = ADW'(addr); cfg_data = AW'(data);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic do_upd();
        upd = 1'b1; cycle(); upd = 1'b0;
    endtask

    task automatic ramp(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            angle = AW'((start + i) % (AMAX + 1));
            cycle();
        end
    endtask

    task automatic seg_begin(input int id);
        g_seg = id; g_cnt = 1'b1;
    endtask

    task automatic seg_end(input int ehi, input int ep);
        g_cnt = 1'b0;
        cycle(1'b1, ehi, ep);
    endtask

    // Monitor: pops one expectation per clock and also checks per-segment ch0 tallies.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t cur;
            logic [3*CH-1:0] act;
            cur = exp_q.pop_front();
            act = {fault, on_if, out};
            checks++;
            if (act !== cur.e) begin
                failures++;
                $display("FAIL outputs seg=%0d t=%0t actual=%h expected=%h", cur.seg, $time, act, cur.e);
            end
            if (cur.last) begin
                checks++;
                if (hi_cnt != cur.ehi) begin
                    failures++;
                    $display("FAIL seg%0d_high_cycles actual=%0d expected=%0d", cur.seg, hi_cnt, cur.ehi);
                end
                checks++;
                if (pulse_cnt != cur.ep) begin
                    failures++;
                    $display("FAIL seg%0d_on_if_pulses actual=%0d expected=%0d", cur.seg, pulse_cnt, cur.ep);
                end
                hi_cnt = 0; pulse_cnt = 0;
            end else if (cur.cnt) begin
                hi_cnt    += int'(out[0]);
                pulse_cnt += int'(on_if[0]);
            end
        end
    end

    initial begin
        int a;
        rst = 1'b0; ena = 1'b0; upd = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        angle = '0; angle_max = AW'(AMAX); ch_ena = 4'hF; fault_clr = 4'h0;
        repeat (3) cycle();
        rst = 1'b1; ena = 1'b1;

        // 1: basic window
        wr(0, 100); wr(1, 200); do_upd();
        seg_begin(1); ramp(0, 360); seg_end(100, 1);
        // 2: window across the wrap
        wr(0, 350); wr(1, 10); do_upd();
        seg_begin(2); ramp(300, 100); seg_end(20, 1);
        // 3: coarse step crosses on and off together
        wr(0, 100); wr(1, 103); do_upd();
        seg_begin(3); angle = 24'd95; cycle(); cycle(); angle = 24'd105; cycle(); cycle(); seg_end(0, 0);
        // 4: update while active is deferred to pulse end
        wr(0, 100); wr(1, 200); do_upd();
        seg_begin(4); ramp(0, 151); wr(1, 300); do_upd(); ramp(151, 209); seg_end(102, 1);
        seg_begin(5); ramp(0, 360); seg_end(200, 1);
        // 5: dwell limit with frozen angle, then fault clear
        wr(2 * CH, 50);
        seg_begin(6); ramp(90, 21); repeat (70) cycle(); seg_end(DWELL_EN ? 50 : 81, 1);
        fault_clr = 4'h1; cycle(); fault_clr = 4'h0; cycle();
        wr(2 * CH, 0);
        // 6: ena drop and reset mid-pulse
        ramp(0, 151);
        ena = 1'b0; cycle(); ena = 1'b1; cycle();
        seg_begin(7); ramp(151, 49); seg_end(0, 0);
        ramp(200, 160); ramp(0, 151);
        rst = 1'b0; cycle(); rst = 1'b1; cycle();
        wr(0, 100); wr(1, 200); do_upd();
        seg_begin(8); ramp(151, 209); seg_end(0, 0);
        seg_begin(9); ramp(0, 360); seg_end(100, 1);

        // Randomized traffic
        a = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom_range(0, AMAX);
            else a = (a + $urandom_range(0, 40)) % (AMAX + 1);
            angle     = AW'(a);
            rst       = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) ena = ~ena;
            if ($urandom_range(0, 29) == 0) ch_ena = CH'($urandom_range(0, 15));
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = ADW'($urandom_range(0, 15));
            cfg_data  = (cfg_addr == ADW'(2 * CH)) ? AW'($urandom_range(0, 60)) : AW'($urandom_range(0, 400));
            upd       = ($urandom_range(0, 39) == 0);
            fault_clr = ($urandom_range(0, 9) == 0) ? CH'($urandom_range(0, 15)) : 4'h0;
            cycle();
        end
        rst = 1'b1; cfg_we = 1'b0; upd = 1'b0; fault_clr = 4'h0;
        repeat (3) cycle();
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
